// File: rtl/periph_pkg.sv
// Shared constants for the data-side peripheral bus: region base, register
// offsets and the active-low 7-segment hex decode.
package periph_pkg;

  localparam logic [31:0] PERIPH_BASE = 32'hFFFF_F000;

  localparam logic [11:0] OFF_DIG     = 12'h000;
  localparam logic [11:0] OFF_TMR_CNT = 12'h020;
  localparam logic [11:0] OFF_TMR_DIV = 12'h024;
  localparam logic [11:0] OFF_LED     = 12'h060;
  localparam logic [11:0] OFF_SW      = 12'h070;
  localparam logic [11:0] OFF_BTN     = 12'h078;

  // Segment byte is {a,b,c,d,e,f,g,dp}, a 0 lights the segment; dp stays off.
  function automatic logic [7:0] seg_decode(input logic [3:0] v);
    logic [7:0] s;
    s = 8'hFF;
    case (v)
      4'h0: s = 8'h03;
      4'h1: s = 8'h9F;
      4'h2: s = 8'h25;
      4'h3: s = 8'h0D;
      4'h4: s = 8'h99;
      4'h5: s = 8'h49;
      4'h6: s = 8'h41;
      4'h7: s = 8'h1F;
      4'h8: s = 8'h01;
      4'h9: s = 8'h09;
      4'hA: s = 8'h11;
      4'hB: s = 8'hC1;
      4'hC: s = 8'h63;
      4'hD: s = 8'h85;
      4'hE: s = 8'h61;
      4'hF: s = 8'h71;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/periph_bus_seg_scan.sv
// seg_scan: multiplexed 8-digit 7-segment driver; each digit is held for
// SCAN_DIV clocks, then the scan advances to the next digit.
module seg_scan
  import periph_pkg::*;
#(
  parameter int SCAN_DIV = 20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dig,
  output logic [7:0]  dig_en,
  output logic [7:0]  dig_seg
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [3:0]    nib;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == TC) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  // Decode straight from the live DIG value so a write shows up next cycle.
  assign nib     = dig[{idx_q, 2'b00} +: 4];
  assign dig_en  = ~(8'b1 << idx_q);
  assign dig_seg = seg_decode(nib);

endmodule

// File: rtl/periph_bus.sv
// periph_bus: data-side bus responder splitting core accesses between DRAM and
// the 0xFFFFF000 peripheral page. Timer present when PERIPH_TIMER_EN is defined.
module periph_bus
  import periph_pkg::*;
#(
  parameter int SCAN_DIV = 20000,
  parameter int DRAM_AW  = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cpu_we,
  input  logic [31:0]        cpu_addr,
  input  logic [31:0]        cpu_wdata,
  output logic [31:0]        cpu_rdata,
  output logic               dram_we,
  output logic [DRAM_AW-1:0] dram_addr,
  output logic [31:0]        dram_wdata,
  input  logic [31:0]        dram_rdata,
  input  logic [23:0]        sw,
  input  logic [4:0]         btn,
  output logic [23:0]        led,
  output logic [7:0]         dig_en,
  output logic [7:0]         dig_seg
);

  logic        periph_hit;
  logic [11:0] off;
  logic        wr_dig, wr_led;
  logic [31:0] tmr_cnt_rd, tmr_div_rd;
  logic        unused_addr_bits;

  logic [31:0] dig_q, dig_d;
  logic [23:0] led_q, led_d;
  logic [23:0] sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
  logic [4:0]  btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;

  assign periph_hit       = (cpu_addr[31:12] == PERIPH_BASE[31:12]);
  assign off              = {cpu_addr[11:2], 2'b00};
  assign unused_addr_bits = &{1'b0, cpu_addr[1:0]};

  assign dram_we    = cpu_we & ~periph_hit;
  assign dram_addr  = cpu_addr[DRAM_AW+1:2];
  assign dram_wdata = cpu_wdata;

  always_comb begin
    wr_dig   = cpu_we & periph_hit & (off == OFF_DIG);
    wr_led   = cpu_we & periph_hit & (off == OFF_LED);
    dig_d    = wr_dig ? cpu_wdata : dig_q;
    led_d    = wr_led ? cpu_wdata[23:0] : led_q;
    sw_s1_d  = sw;
    sw_s2_d  = sw_s1_q;
    btn_s1_d = btn;
    btn_s2_d = btn_s1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig_q    <= '0;
      led_q    <= '0;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      btn_s1_q <= '0;
      btn_s2_q <= '0;
    end else begin
      dig_q    <= dig_d;
      led_q    <= led_d;
      sw_s1_q  <= sw_s1_d;
      sw_s2_q  <= sw_s2_d;
      btn_s1_q <= btn_s1_d;
      btn_s2_q <= btn_s2_d;
    end
  end

`ifdef PERIPH_TIMER_EN
  logic [31:0] tmr_cnt_q, tmr_cnt_d, tmr_div_q, tmr_div_d, presc_q, presc_d;
  logic        wr_cnt, wr_div, tick;

  // A TMR_CNT write overrides a coincident tick; any timer write restarts the prescaler.
  always_comb begin
    wr_cnt    = cpu_we & periph_hit & (off == OFF_TMR_CNT);
    wr_div    = cpu_we & periph_hit & (off == OFF_TMR_DIV);
    tick      = (presc_q == tmr_div_q);
    tmr_cnt_d = tick ? tmr_cnt_q + 32'd1 : tmr_cnt_q;
    tmr_div_d = tmr_div_q;
    presc_d   = tick ? '0 : presc_q + 32'd1;
    if (wr_cnt) begin
      tmr_cnt_d = cpu_wdata;
      presc_d   = '0;
    end
    if (wr_div) begin
      tmr_div_d = cpu_wdata;
      presc_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr_cnt_q <= '0;
      tmr_div_q <= '0;
      presc_q   <= '0;
    end else begin
      tmr_cnt_q <= tmr_cnt_d;
      tmr_div_q <= tmr_div_d;
      presc_q   <= presc_d;
    end
  end

  assign tmr_cnt_rd = tmr_cnt_q;
  assign tmr_div_rd = tmr_div_q;
`else
  assign tmr_cnt_rd = '0;
  assign tmr_div_rd = '0;
`endif

  always_comb begin
    cpu_rdata = dram_rdata;
    if (periph_hit) begin
      cpu_rdata = '0;
      case (off)
        OFF_DIG:     cpu_rdata = dig_q;
        OFF_LED:     cpu_rdata = {8'h00, led_q};
        OFF_SW:      cpu_rdata = {8'h00, sw_s2_q};
        OFF_BTN:     cpu_rdata = {27'h0, btn_s2_q};
        OFF_TMR_CNT: cpu_rdata = tmr_cnt_rd;
        OFF_TMR_DIV: cpu_rdata = tmr_div_rd;
        default:     cpu_rdata = '0;
      endcase
    end
  end

  assign led = led_q;

  seg_scan #(.SCAN_DIV(SCAN_DIV)) u_seg_scan (
    .clk     (clk),
    .rst     (rst),
    .dig     (dig_q),
    .dig_en  (dig_en),
    .dig_seg (dig_seg)
  );

endmodule

// File: tb/tb_periph_bus.sv
// Self-checking bench for periph_bus: directed cases then randomized bus traffic
// against a closed-form model of registers, synchronizers, scan and timer.
module tb_periph_bus;

  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        dram_we;
  logic [13:0] dram_addr;
  logic [31:0] dram_wdata;
  logic [31:0] dram_rdata = '0;
  logic [23:0] sw = '0;
  logic [4:0]  btn = '0;
  logic [23:0] led;
  logic [7:0]  dig_en, dig_seg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [23:0] sw_at [4] = '{default: '0};
  logic [4:0]  btn_at[4] = '{default: '0};
  logic [31:0] dig_m = '0;
  logic [23:0] led_m = '0;
  logic [31:0] tmr_base = '0;
  int          tmr_t0 = 0;
  int          tmr_div_m = 0;
  logic [7:0]  seg_ref[16];
  logic [11:0] offs[7];
  logic [31:0] exp_q[$];

  periph_bus #(.SCAN_DIV(SD), .DRAM_AW(14)) dut (
    .clk(clk), .rst(rst), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .dram_we(dram_we),
    .dram_addr(dram_addr), .dram_wdata(dram_wdata), .dram_rdata(dram_rdata),
    .sw(sw), .btn(btn), .led(led), .dig_en(dig_en), .dig_seg(dig_seg)
  );

  // ---------------- clock / reset / edge history ----------------
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc = 0;
      for (int i = 0; i < 4; i++) begin
        sw_at[i]  = '0;
        btn_at[i] = '0;
      end
    end else begin
      cyc = cyc + 1;
      sw_at[cyc % 4]  = sw;
      btn_at[cyc % 4] = btn;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] tmr_now();
`ifdef PERIPH_TIMER_EN
    return tmr_base + 32'((cyc - tmr_t0) / (tmr_div_m + 1));
`else
    return 32'h0;
`endif
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [11:0] o;
    o = {a[11:2], 2'b00};
    if (a[31:12] != 20'hFFFFF) return dram_rdata;
    case (o)
      12'h000: return dig_m;
      12'h060: return {8'h00, led_m};
      12'h070: return (cyc >= 2) ? {8'h00, sw_at[(cyc - 1) % 4]} : 32'h0;
      12'h078: return (cyc >= 2) ? {27'h0, btn_at[(cyc - 1) % 4]} : 32'h0;
`ifdef PERIPH_TIMER_EN
      12'h020: return tmr_now();
      12'h024: return 32'(tmr_div_m);
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    dig_m     = '0;
    led_m     = '0;
    tmr_base  = '0;
    tmr_t0    = 0;
    tmr_div_m = 0;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h (t=%0t cyc=%0d)", tag, got, exp, $time, cyc);
    end
  endtask

  task automatic chk_display();
    int         idx;
    logic [3:0] nib;
    logic [7:0] e_en;
    idx  = (cyc / SD) % 8;
    nib  = 4'(dig_m >> (4 * idx));
    e_en = ~(8'h01 << idx);
    check("dig_en", {24'h0, dig_en}, {24'h0, e_en});
    check("dig_seg", {24'h0, dig_seg}, {24'h0, seg_ref[nib]});
  endtask

  // ---------------- drivers ----------------
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    logic [11:0] o;
    logic        ph;
    o  = {a[11:2], 2'b00};
    ph = (a[31:12] == 20'hFFFFF);
    @(negedge clk);
    cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d; dram_rdata = $urandom;
    #1;
    check($sformatf("wr_old_rdata@%08h", a), cpu_rdata, model_read(a));
    if (!ph) begin
      check("dram_we", {31'h0, dram_we}, 32'h1);
      check("dram_addr", {18'h0, dram_addr}, {18'h0, a[15:2]});
      check("dram_wdata", dram_wdata, d);
    end else begin
      check("dram_we_periph", {31'h0, dram_we}, 32'h0);
    end
    @(posedge clk);
    #1;
    cpu_we = 1'b0;
    if (ph) begin
      case (o)
        12'h000: dig_m = d;
        12'h060: led_m = d[23:0];
`ifdef PERIPH_TIMER_EN
        12'h020: begin tmr_base = d; tmr_t0 = cyc; end
        12'h024: begin tmr_base = tmr_now(); tmr_t0 = cyc; tmr_div_m = int'(d); end
`endif
        default: ;
      endcase
    end
  endtask

  task automatic bus_read(input logic [31:0] a);
    @(negedge clk);
    cpu_addr = a; dram_rdata = $urandom;
    #1;
    exp_q.push_back(model_read(a));
    check($sformatf("rd@%08h", a), cpu_rdata, exp_q.pop_front());
    check("dram_we_rd", {31'h0, dram_we}, 32'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    seg_ref = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};
    offs    = '{12'h000, 12'h060, 12'h070, 12'h078, 12'h020, 12'h024, 12'h0A4};
    model_reset();

    // reset state
    #2;
    check("rst_led", {8'h0, led}, 32'h0);
    check("rst_dig_en", {24'h0, dig_en}, 32'hFE);
    check("rst_dig_seg", {24'h0, dig_seg}, 32'h03);
    @(negedge clk);
    rst = 1'b0;

    // DRAM pass-through
    bus_write(32'h0000_0040, 32'h0000_1234);
    bus_read(32'h0000_0040);

    // LEDs
    bus_write(32'hFFFF_F060, 32'h00A5_A5A5);
    check("led_out", {8'h0, led}, 32'h00A5_A5A5);
    bus_read(32'hFFFF_F060);

    // switch synchronizer latency
    @(negedge clk);
    sw = 24'h00F00F;
    btn = 5'h15;
    bus_read(32'hFFFF_F070);
    bus_read(32'hFFFF_F070);
    check("sw_2nd_edge", cpu_rdata, 32'h0000_F00F);
    bus_read(32'hFFFF_F078);

    // display scan across a full wrap
    bus_write(32'hFFFF_F000, 32'h0000_0821);
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      #1;
      chk_display();
    end

    // unlisted offset and RO write
    bus_write(32'hFFFF_F0A4, 32'hDEAD_BEEF);
    bus_read(32'hFFFF_F0A4);
    bus_write(32'hFFFF_F070, 32'h0012_3456);
    bus_read(32'hFFFF_F070);

`ifdef PERIPH_TIMER_EN
    bus_write(32'hFFFF_F024, 32'd2);
    bus_write(32'hFFFF_F020, 32'd0);
    for (int i = 0; i < 10; i++) bus_read(32'hFFFF_F020);
    bus_write(32'hFFFF_F020, 32'hFFFF_FFFF);
    for (int i = 0; i < 4; i++) bus_read(32'hFFFF_F020);
    check("tmr_wrap", cpu_rdata, 32'h0);
    bus_write(32'hFFFF_F020, 32'h0000_0010);
    bus_read(32'hFFFF_F020);
    bus_read(32'hFFFF_F020);
    bus_write(32'hFFFF_F020, 32'h0000_0500);
    bus_read(32'hFFFF_F020);
    check("tmr_write_wins", cpu_rdata, 32'h0000_0500);
`else
    bus_write(32'hFFFF_F020, 32'h1234_5678);
    bus_read(32'hFFFF_F020);
    bus_write(32'hFFFF_F024, 32'h0000_0003);
    bus_read(32'hFFFF_F024);
`endif

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a, d;
      int r;
      r = $urandom_range(0, 9);
      if (r < 3) begin
        a = $urandom;
        if (a[31:12] == 20'hFFFFF) a[31] = 1'b0;
      end else begin
        a = 32'hFFFF_F000 | {20'h0, offs[r - 3]} | 32'($urandom_range(0, 3));
      end
      d = $urandom;
      if (offs[r % 7] == 12'h024 && r >= 3) d = 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        sw  = 24'($urandom);
        btn = 5'($urandom);
      end
      if ($urandom_range(0, 1) == 0) bus_write(a, d);
      else bus_read(a);
      if (n % 8 == 0) chk_display();
    end

    // asynchronous reset mid-operation
    bus_write(32'hFFFF_F060, 32'h0012_3456);
    bus_write(32'hFFFF_F000, 32'hFEDC_BA98);
    cpu_addr = 32'hFFFF_F020;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check("mid_rst_led", {8'h0, led}, 32'h0);
    check("mid_rst_dig_en", {24'h0, dig_en}, 32'hFE);
    check("mid_rst_dig_seg", {24'h0, dig_seg}, 32'h03);
    check("mid_rst_tmr", cpu_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus_read(32'hFFFF_F060);
    bus_read(32'hFFFF_F000);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      chk_display();
    end
    bus_read(32'hFFFF_F020);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
